// File: rtl/evm_winner_scan.sv
// rtl/evm_winner_scan.sv - result-phase winner scan over snapshotted vote counts via a shared comparator
module evm_winner_scan #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 4,
    parameter int IDX_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [NUM_CAND*CNT_W-1:0] counts,
    output logic                      busy,
    output logic                      done,
    output logic [IDX_W-1:0]          winner_idx,
    output logic [CNT_W-1:0]          winner_count,
    output logic                      tie,
    output logic                      cmp_en,
    output logic [CNT_W-1:0]          cmp_a,
    output logic [CNT_W-1:0]          cmp_b,
    input  logic                      cmp_gt,
    input  logic                      cmp_eq,
    input  logic                      cmp_lt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    state_t                    state_q, state_d;
    logic [NUM_CAND*CNT_W-1:0] snap_q, snap_d;
    logic [CNT_W-1:0]          max_q, max_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      run_tie_q, run_tie_d;
    logic [IDX_W-1:0]          i_q, i_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [IDX_W-1:0]          win_idx_q, win_idx_d;
    logic [CNT_W-1:0]          win_cnt_q, win_cnt_d;
    logic                      win_tie_q, win_tie_d;
    logic [CNT_W-1:0]          cand_sel;
    logic                      unused_cmp_lt;

    // The A<B line is redundant with gt/eq; only the bench looks at it.
    assign unused_cmp_lt = cmp_lt;

    // Select the snapshotted count of the candidate currently under test.
    always_comb begin
        cand_sel = '0;
        for (int c = 0; c < NUM_CAND; c++) begin
            if (i_q == IDX_W'(c)) begin
                cand_sel = snap_q[c*CNT_W +: CNT_W];
            end
        end
    end

    // Comparator drive is decoded from state so it is quiet outside SCAN.
    always_comb begin
        cmp_en = (state_q == S_SCAN);
        cmp_a  = cmp_en ? cand_sel : '0;
        cmp_b  = cmp_en ? max_q    : '0;
    end

    // Next-state logic: snapshot on start, walk one candidate per cycle, publish on exit from SCAN.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        max_d     = max_q;
        idx_d     = idx_q;
        run_tie_d = run_tie_q;
        i_d       = i_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        win_idx_d = win_idx_q;
        win_cnt_d = win_cnt_q;
        win_tie_d = win_tie_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d    = counts;
                    max_d     = counts[CNT_W-1:0];
                    idx_d     = '0;
                    run_tie_d = 1'b0;
                    i_d       = IDX_W'(1);
                    if (NUM_CAND == 1) begin
                        // A lone candidate wins outright with no comparisons.
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        win_cnt_d = counts[CNT_W-1:0];
                        win_idx_d = '0;
                        win_tie_d = 1'b0;
                    end else begin
                        state_d = S_SCAN;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                // Only a strict win replaces the leader, so ties keep the lowest index.
                if (cmp_gt) begin
                    max_d     = cand_sel;
                    idx_d     = i_q;
                    run_tie_d = 1'b0;
                end else if (cmp_eq) begin
                    run_tie_d = 1'b1;
                end
                if (i_q == LAST_IDX) begin
                    // Results are registered on the way into DONE so they appear with the done pulse.
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    win_cnt_d = max_d;
                    win_idx_d = idx_d;
                    win_tie_d = run_tie_d;
                end else begin
                    i_d    = i_q + IDX_W'(1);
                    busy_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any scan without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            snap_q    <= '0;
            max_q     <= '0;
            idx_q     <= '0;
            run_tie_q <= 1'b0;
            i_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            win_idx_q <= '0;
            win_cnt_q <= '0;
            win_tie_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            run_tie_q <= run_tie_d;
            i_q       <= i_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            win_idx_q <= win_idx_d;
            win_cnt_q <= win_cnt_d;
            win_tie_q <= win_tie_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign winner_idx   = win_idx_q;
    assign winner_count = win_cnt_q;
    assign tie          = win_tie_q;

endmodule
